// File: rtl/linear_tiled_if.sv
// ----------------------------------------------------------------------------
// linear_tiled_if
// Bundle of the handshake, operand and weight-memory signals of linear_tiled.
// Signal directions are named from the engine's point of view.
//
//   start_i   begin an inference (sampled only while the engine is idle)
//   x_i       IN signed XW-bit inputs, element i at [i*XW +: XW]
//   bias_i    OUT signed OW-bit biases, element o at [o*OW +: OW]
//   w_rd_o    weight read strobe
//   w_addr_o  weight chunk address = o*CH + c
//   w_data_i  LANES signed WW-bit weights, lane l at [l*WW +: WW],
//             valid exactly one cycle after w_rd_o
//   busy_o    engine working
//   done_o    one-cycle pulse, y_o complete
//   y_o       OUT signed OW-bit results, element o at [o*OW +: OW]
//
// Modports: slave  = the engine (linear_tiled)
//           master = the host / weight memory side
// ----------------------------------------------------------------------------
interface linear_tiled_if #(
    parameter int IN    = 256,
    parameter int OUT   = 16,
    parameter int LANES = 16,
    parameter int XW    = 8,
    parameter int WW    = 8,
    parameter int OW    = 16
);
    localparam int CH = IN / LANES;
    localparam int AW = (OUT * CH > 1) ? $clog2(OUT * CH) : 1;

    logic                  start_i;
    logic [IN*XW-1:0]      x_i;
    logic [OUT*OW-1:0]     bias_i;
    logic                  w_rd_o;
    logic [AW-1:0]         w_addr_o;
    logic [LANES*WW-1:0]   w_data_i;
    logic                  busy_o;
    logic                  done_o;
    logic [OUT*OW-1:0]     y_o;

    modport slave (
        input  start_i, x_i, bias_i, w_data_i,
        output w_rd_o, w_addr_o, busy_o, done_o, y_o
    );

    modport master (
        output start_i, x_i, bias_i, w_data_i,
        input  w_rd_o, w_addr_o, busy_o, done_o, y_o
    );
endinterface

// File: rtl/linear_tiled.sv
// ----------------------------------------------------------------------------
// linear_tiled
// Fully connected layer y = clamp((W*x + bias) >>> SHIFT) for an NNUE-style
// network.  A LANES-wide multiply-accumulate walks over the input vector one
// chunk per cycle; the weights stream in from an external single-port memory
// that returns one row chunk one cycle after each read strobe.
//
// Ports
//   clk   clock, rising edge
//   rst   synchronous reset, active-high; aborts any inference in flight
//   bus   linear_tiled_if.slave: start_i, x_i, bias_i, w_data_i in;
//         w_rd_o, w_addr_o, busy_o, done_o, y_o out
//
// Sequence: IDLE -(start)-> RUN (OUT*CH reads) -> DRAIN (last MAC) -> DONE
// (done pulse) -> IDLE.  Start sampled in cycle 0 gives reads in cycles
// 1..OUT*CH and done in cycle OUT*CH+2.
//
// Build option: define LINEAR_CRELU_EN to replace the signed OW-bit
// saturation of each result with a ClippedReLU to [0, 127].  Timing and
// handshake are the same in both builds.
// ----------------------------------------------------------------------------
module linear_tiled #(
    parameter int IN    = 256,
    parameter int OUT   = 16,
    parameter int LANES = 16,
    parameter int XW    = 8,
    parameter int WW    = 8,
    parameter int OW    = 16,
    parameter int ACCW  = 32,
    parameter int SHIFT = 0
) (
    input  logic          clk,
    input  logic          rst,
    linear_tiled_if.slave bus
);
    localparam int CH  = IN / LANES;
    localparam int NRD = OUT * CH;
    localparam int AW  = (NRD > 1) ? $clog2(NRD) : 1;
    localparam int CW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int OCW = (OUT > 1) ? $clog2(OUT) : 1;

    localparam logic [AW-1:0] ADDR_LAST = AW'(NRD - 1);
    localparam logic [CW-1:0] C_LAST    = CW'(CH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Result clamp applied after bias add and shift
    // ------------------------------------------------------------------
`ifdef LINEAR_CRELU_EN
    localparam logic signed [ACCW-1:0] CRELU_MAX = ACCW'(127);

    function automatic logic signed [OW-1:0] clamp_out(input logic signed [ACCW-1:0] v);
        if (v < 0) begin
            return '0;
        end else if (v > CRELU_MAX) begin
            return OW'(127);
        end else begin
            return v[OW-1:0];
        end
    endfunction
`else
    localparam logic signed [ACCW-1:0] OMAX = ACCW'((longint'(1) <<< (OW - 1)) - 1);
    localparam logic signed [ACCW-1:0] OMIN = ~OMAX;

    function automatic logic signed [OW-1:0] clamp_out(input logic signed [ACCW-1:0] v);
        if (v > OMAX) begin
            return OMAX[OW-1:0];
        end else if (v < OMIN) begin
            return OMIN[OW-1:0];
        end else begin
            return v[OW-1:0];
        end
    endfunction
`endif

    // Control state
    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   c_q, c_d;
    logic [OCW-1:0]  o_q, o_d;
    logic            accept;

    // Operand latches (captured on accepted start, never reset)
    logic [IN*XW-1:0]   x_q;
    logic [OUT*OW-1:0]  bias_q;

    // Read-return stage
    logic               vld_p1;
    logic [CW-1:0]      c_p1;
    logic [OCW-1:0]     o_p1;

    // Accumulator and results
    logic signed [ACCW-1:0] acc_q;
    logic [OUT*OW-1:0]      y_q;

    logic signed [ACCW-1:0] mac_sum;
    logic signed [ACCW-1:0] acc_sum;
    logic signed [ACCW-1:0] res_sh;
    logic signed [OW-1:0]   y_el;
    logic signed [XW-1:0]   xe;
    logic signed [WW-1:0]   we;
    logic signed [OW-1:0]   be;

    // ------------------------------------------------------------------
    // FSM and read-address generation
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            c_q     <= '0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            c_q     <= c_d;
            o_q     <= o_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        c_d     = c_q;
        o_d     = o_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                    addr_d  = '0;
                    c_d     = '0;
                    o_d     = '0;
                end
            end
            S_RUN: begin
                // Chunk-major walk: c is the low-order digit of the address.
                addr_d = addr_q + AW'(1);
                if (c_q == C_LAST) begin
                    c_d = '0;
                    o_d = o_q + OCW'(1);
                end else begin
                    c_d = c_q + CW'(1);
                end
                if (addr_q == ADDR_LAST) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.w_rd_o   = (state_q == S_RUN);
    assign bus.w_addr_o = addr_q;
    assign bus.busy_o   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done_o   = (state_q == S_DONE);
    assign bus.y_o      = y_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            x_q    <= bus.x_i;
            bias_q <= bus.bias_i;
        end
    end

    // ------------------------------------------------------------------
    // p1: weight chunk returned by memory, multiply-accumulate
    // ------------------------------------------------------------------
    always_comb begin
        mac_sum = '0;
        xe      = '0;
        we      = '0;
        for (int l = 0; l < LANES; l++) begin
            xe      = x_q[(int'(c_p1) * LANES + l) * XW +: XW];
            we      = bus.w_data_i[l * WW +: WW];
            mac_sum = mac_sum + (ACCW'(xe) * ACCW'(we));
        end
        acc_sum = acc_q + mac_sum;
        be      = bias_q[int'(o_p1) * OW +: OW];
        res_sh  = (acc_sum + ACCW'(be)) >>> SHIFT;
        y_el    = clamp_out(res_sh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            c_p1   <= '0;
            o_p1   <= '0;
            acc_q  <= '0;
            y_q    <= '0;
        end else begin
            vld_p1 <= (state_q == S_RUN);
            c_p1   <= c_q;
            o_p1   <= o_q;
            if (accept) begin
                acc_q <= '0;
            end else if (vld_p1) begin
                if (c_p1 == C_LAST) begin
                    // Final chunk: write the result and restart the sum so the
                    // next output's first chunk lands on zero with no bubble.
                    y_q[int'(o_p1) * OW +: OW] <= y_el;
                    acc_q                      <= '0;
                end else begin
                    acc_q <= acc_sum;
                end
            end
        end
    end

endmodule
